// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer with HUNT/LOCKED frame alignment and sync-error flagging.
// Optional frame counter enabled by defining TDM_FRAME_CNT_EN.
module tdm_demux4 #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   d,
    input  logic           dv,
    input  logic           fs,
    output logic [4*W-1:0] y,
    output logic [3:0]     yv,
    output logic           frame_done,
    output logic           locked,
    output logic           sync_err,
    output logic [7:0]     frame_cnt
);

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [1:0]     slot_q, slot_d;
    logic [4*W-1:0] y_q, y_d;
    logic [3:0]     yv_q, yv_d;
    logic           fd_q, fd_d;
    logic           err_q, err_d;
    logic           wr_en;
    logic [1:0]     wr_ch;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        wr_en   = 1'b0;
        wr_ch   = 2'd0;
        fd_d    = 1'b0;
        err_d   = 1'b0;
        if (dv) begin
            case (state_q)
                HUNT: begin
                    if (fs) begin
                        wr_en   = 1'b1;
                        slot_d  = 2'd1;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (fs) begin
                        // early sync restarts the frame without closing the truncated one
                        err_d  = (slot_q != 2'd0);
                        wr_en  = 1'b1;
                        slot_d = 2'd1;
                    end else if (slot_q == 2'd0) begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end else begin
                        wr_en  = 1'b1;
                        wr_ch  = slot_q;
                        fd_d   = (slot_q == 2'd3);
                        slot_d = slot_q + 2'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        y_d  = y_q;
        yv_d = 4'b0000;
        if (wr_en) begin
            y_d[wr_ch*W +: W] = d;
            yv_d              = 4'b0001 << wr_ch;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
            slot_q  <= 2'd0;
            y_q     <= '0;
            yv_q    <= 4'b0000;
            fd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
            fd_q    <= fd_d;
            err_q   <= err_d;
        end
    end

`ifdef TDM_FRAME_CNT_EN
    logic [7:0] fc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fc_q <= 8'd0;
        end else if (fd_d) begin
            fc_q <= fc_q + 8'd1;
        end
    end

    assign frame_cnt = fc_q;
`else
    assign frame_cnt = 8'd0;
`endif

    assign y          = y_q;
    assign yv         = yv_q;
    assign frame_done = fd_q;
    assign locked     = (state_q == LOCKED);
    assign sync_err   = err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: a reference model queues expected outputs per driven cycle.
// Honors TDM_FRAME_CNT_EN for the expected frame_cnt.
module tb_tdm_demux4;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   d;
    logic           dv;
    logic           fs;
    logic [4*W-1:0] y;
    logic [3:0]     yv;
    logic           frame_done;
    logic           locked;
    logic           sync_err;
    logic [7:0]     frame_cnt;

    tdm_demux4 #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d          (d),
        .dv         (dv),
        .fs         (fs),
        .y          (y),
        .yv         (yv),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] y;
        logic [3:0]  yv;
        logic        fd;
        logic        lk;
        logic        err;
        logic [7:0]  fc;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] m_y;
    logic [1:0]  m_slot;
    logic        m_lk;
    logic [7:0]  m_fc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic f, input logic [7:0] dd);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        dv    = v;
        fs    = f;
        d     = dd;
        e.yv  = 4'b0000;
        e.fd  = 1'b0;
        e.err = 1'b0;
        if (!r) begin
            m_y = '0; m_slot = 2'd0; m_lk = 1'b0; m_fc = 8'd0;
        end else if (v) begin
            if (!m_lk) begin
                if (f) begin
                    m_y[7:0] = dd; e.yv = 4'b0001; m_slot = 2'd1; m_lk = 1'b1;
                end
            end else if (f) begin
                e.err = (m_slot != 2'd0);
                m_y[7:0] = dd; e.yv = 4'b0001; m_slot = 2'd1;
            end else if (m_slot == 2'd0) begin
                e.err = 1'b1; m_lk = 1'b0;
            end else begin
                case (m_slot)
                    2'd1: m_y[15:8]  = dd;
                    2'd2: m_y[23:16] = dd;
                    default: begin
                        m_y[31:24] = dd;
                        e.fd = 1'b1;
`ifdef TDM_FRAME_CNT_EN
                        m_fc = m_fc + 8'd1;
`endif
                    end
                endcase
                e.yv   = 4'b0001 << m_slot;
                m_slot = m_slot + 2'd1;
            end
        end
        e.y  = m_y;
        e.lk = m_lk;
        e.fc = m_fc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("y",          y,          e.y);
            check("yv",         {28'd0, yv}, {28'd0, e.yv});
            check("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
            check("locked",     {31'd0, locked},     {31'd0, e.lk});
            check("sync_err",   {31'd0, sync_err},   {31'd0, e.err});
            check("frame_cnt",  {24'd0, frame_cnt},  {24'd0, e.fc});
        end
    endtask

    task automatic send(input logic f, input logic [7:0] dd);
        step(1'b1, 1'b1, f, dd);
    endtask

    initial begin
        logic [7:0] fc_before;
        rst_n = 1'b0; dv = 1'b0; fs = 1'b0; d = '0;
        m_y = '0; m_slot = 2'd0; m_lk = 1'b0; m_fc = 8'd0;

        // reset state
        step(1'b0, 1'b1, 1'b1, 8'hFF);
        check("rst_y",      y, 32'h0);
        check("rst_locked", {31'd0, locked}, 32'd0);

        // one complete aligned frame, back to back
        send(1'b1, 8'h11);
        check("t1_lock_first", {31'd0, locked}, 32'd1);
        send(1'b0, 8'h22);
        send(1'b0, 8'h33);
        send(1'b0, 8'h44);
        check("t1_y",  y, 32'h44332211);
        check("t1_fd", {31'd0, frame_done}, 32'd1);
        check("t1_yv", {28'd0, yv}, 32'h8);

        // hunt discards samples without fs
        step(1'b0, 1'b0, 1'b0, 8'h00);
        send(1'b0, 8'hAA);
        send(1'b0, 8'hBB);
        check("t2_drop_y", y, 32'h0);
        send(1'b1, 8'h01);
        check("t2_y",  y, 32'h00000001);
        check("t2_lk", {31'd0, locked}, 32'd1);

        // early sync
        send(1'b0, 8'h02); send(1'b0, 8'h03); send(1'b0, 8'h04);
        send(1'b1, 8'h10); send(1'b0, 8'h20); send(1'b1, 8'h30);
        check("t3_err", {31'd0, sync_err}, 32'd1);
        check("t3_ch0", {24'd0, y[7:0]}, 32'h30);
        send(1'b0, 8'h21);
        check("t3_ch1", {24'd0, y[15:8]}, 32'h21);
        send(1'b0, 8'h31); send(1'b0, 8'h41);

        // missing sync after a complete frame, then relock
        send(1'b0, 8'h55);
        check("t4_err", {31'd0, sync_err}, 32'd1);
        check("t4_lk",  {31'd0, locked}, 32'd0);
        check("t4_y",   y, 32'h41312130);
        send(1'b1, 8'h66);
        check("t4_relock", {31'd0, locked}, 32'd1);
        send(1'b0, 8'h67); send(1'b0, 8'h68); send(1'b0, 8'h69);

        // 256 frames with random gaps
        fc_before = frame_cnt;
        for (int fr = 0; fr < 256; fr++) begin
            for (int s = 0; s < 4; s++) begin
                if ($urandom_range(0, 2) == 0) step(1'b1, 1'b0, $urandom_range(0, 1), 8'($urandom));
                send(s == 0, 8'($urandom));
            end
        end
        check("t5_wrap", {24'd0, frame_cnt}, {24'd0, fc_before});

        // reset after slot 2
        send(1'b1, 8'hA0); send(1'b0, 8'hA1); send(1'b0, 8'hA2);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("t6_y",  y, 32'h0);
        check("t6_fc", {24'd0, frame_cnt}, 32'd0);
        send(1'b0, 8'hA3);
        check("t6_drop", y, 32'h0);
        check("t6_lk",   {31'd0, locked}, 32'd0);

        if (exp_q.size() != 0) check("sb_leftover", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer, the receive-side counterpart of the team's 4:1 channel multiplexer. It accepts a stream of W-bit samples tagged with a frame-sync marker and steers each sample to one of four registered channel outputs. It tracks slot position with a 2-bit slot counter and a HUNT/LOCKED alignment state machine, and flags sync errors. It sits between the serial/TDM link front end and the per-channel processing logic.

## Interface
Parameters:
- W, default 8: sample width in bits.

Ports:
- clk, input, 1: single clock; all state changes on its rising edge.
- rst_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
- d, input, W: incoming sample.
- dv, input, 1: sample valid; d and fs are ignored when low.
- fs, input, 1: frame sync; when high with dv, marks d as slot 0.
- y, output, 4*W: channel registers; channel n occupies y[n*W +: W].
- yv, output, 4: one-cycle strobe; yv[n] is high when channel n was updated on the previous edge.
- frame_done, output, 1: one-cycle strobe when slot 3 of an aligned frame is written.
- locked, output, 1: high while in the LOCKED state.
- sync_err, output, 1: one-cycle strobe when an alignment violation is detected.
- frame_cnt, output, 8: count of completed frames (see Configuration).

## Operation
- State machine has two states: HUNT and LOCKED. Internal 2-bit slot counter holds the expected slot of the next sample.
- Cycles with dv=0: no state change. y holds its value. yv, frame_done and sync_err are 0.

HUNT:
- dv=1, fs=0: sample is discarded; no strobes.
- dv=1, fs=1: d is written to channel 0 and yv[0] pulses. Slot counter becomes 1. Next state is LOCKED.

LOCKED:
- dv=1, fs=0, slot≠0: d is written to channel[slot] and yv[slot] pulses. Slot counter increments.
- On a write to slot 3, frame_done pulses and the slot counter wraps to 0.
- dv=1, fs=1, slot=0: normal frame start. d is written to channel 0 and slot counter becomes 1.
- dv=1, fs=1, slot≠0 (early sync): sync_err pulses. d is written to channel 0 and slot counter becomes 1. No frame_done is issued for the truncated frame. State remains LOCKED.
- dv=1, fs=0, slot=0 (missing sync): sync_err pulses and the sample is discarded. Slot counter becomes 0. Next state is HUNT.

General rules:
- Only one channel is written per cycle, so at most one bit of yv is high.
- Channels not written in a cycle retain their previous values.

## Timing
- Latency is one cycle. A sample accepted at edge k appears on y, together with its yv, frame_done and sync_err strobes, immediately after edge k and stays valid for the following cycle.
- Every output is registered; there are no combinational input-to-output paths.
- Reset values: y=0, yv=0, frame_done=0, locked=0, sync_err=0, frame_cnt=0. On reset the state is HUNT and the slot counter is 0.
- Reset has priority over dv. Reset asserted mid-frame discards the partial frame. The first sample accepted after reset must carry fs.
- Back-to-back dv on every cycle is supported at full rate, one sample per clock.
- locked rises on the edge that accepts the first fs in HUNT. locked falls on the edge that detects a missing sync.

## Configuration
- Macro: TDM_FRAME_CNT_EN.
- Defined: frame_cnt is an 8-bit register, reset to 0. It increments on every edge that produces frame_done and wraps from 255 to 0. sync_err does not change it.
- Not defined: frame_cnt is driven constant 0 and no counter logic is generated. All other behaviour is identical.

## Test plan
- Reset, then dv=1 with d=0x11 (fs=1), 0x22, 0x33, 0x44 on consecutive cycles -> y=0x44332211, yv sequence 1,2,4,8 (hex), frame_done one pulse with yv[3], locked=1 from the first sample, frame_cnt=1.
- In HUNT, send 0xAA, 0xBB with fs=0, then 0x01 with fs=1 -> first two samples dropped, y=0x00000001, yv=1, locked rises only on the third sample.
- While locked, send slot0=0x10 (fs=1), slot1=0x20, then 0x30 with fs=1 -> sync_err pulse on the third sample, channel 0=0x30, no frame_done, locked stays 1, next sample goes to channel 1.
- After a complete frame, send 0x55 with fs=0 -> sync_err pulse, locked=0, y unchanged, yv=0; the following fs=1 sample relocks.
- Send 256 complete frames with gaps where dv=0 between samples -> outputs hold during the gaps. With TDM_FRAME_CNT_EN defined, frame_cnt wraps to 0 after 256 frames. Without the macro, frame_cnt stays 0 throughout.
- Assert rst_n=0 for one cycle after slot 2 of a frame -> all outputs 0 and locked=0; a slot-3-position sample with fs=0 afterwards is dropped.
